// File: rtl/sequential_divider_if.sv
// rtl/sequential_divider_if.sv - start/ready handshake and operand/result bundle for the sequential divider
interface sequential_divider_if #(
   parameter int N = 4
);
   logic         start;
   logic         ready;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   modport master (
      output start,
      output dividend,
      output divisor,
      input  ready,
      input  quotient,
      input  remainder,
      input  div_by_zero
   );

   modport slave (
      input  start,
      input  dividend,
      input  divisor,
      output ready,
      output quotient,
      output remainder,
      output div_by_zero
   );
endinterface

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - unsigned restoring divider, one quotient bit per clock
module sequential_divider #(
   parameter int N = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   sequential_divider_if.slave   bus
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Dividend shift register: holds the latched dividend, then fills with
   // quotient bits from the LSB as dividend bits leave from the MSB.
   logic [N-1:0]  shreg;
   logic [N-1:0]  dvs;
   // Running remainder. The restoring step keeps it below the divisor, so
   // its (N+1)-th bit is always zero and only N bits are stored.
   logic [N-1:0]  partial;
   logic [CW-1:0] cnt;

   logic [N:0]    trial;
   logic [N-1:0]  diff;
   logic          ge;
   logic          accept;

   logic          rdy;
   logic [N-1:0]  quo;
   logic [N-1:0]  rem;
   logic          dbz;

   assign bus.ready       = rdy;
   assign bus.quotient    = quo;
   assign bus.remainder   = rem;
   assign bus.div_by_zero = dbz;

   // One restoring step: shift in the next dividend bit and compare N+1 wide.
   always_comb begin
      trial = {partial, shreg[N-1]};
      ge    = (trial >= {1'b0, dvs});
      // When ge holds the true difference fits in N bits, so modulo-2^N is exact.
      diff  = trial[N-1:0] - dvs;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; start is only honoured in IDLE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = (bus.divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         dvs     <= '0;
         partial <= '0;
         cnt     <= '0;
         rdy     <= 1'b0;
         quo     <= '0;
         rem     <= '0;
         dbz     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg   <= bus.dividend;
                  dvs     <= bus.divisor;
                  partial <= '0;
                  cnt     <= CW'(N);
                  rdy     <= 1'b0;
                  quo     <= '0;
                  rem     <= '0;
                  dbz     <= 1'b0;
               end
            end
            RUN: begin
               partial <= ge ? diff : trial[N-1:0];
               shreg   <= {shreg[N-2:0], ge};
               cnt     <= cnt - CW'(1);
            end
            DONE: begin
               // A zero divisor skips RUN, so shreg still holds the dividend.
               if (dvs == '0) begin
                  quo <= '1;
                  rem <= shreg;
                  dbz <= 1'b1;
               end else begin
                  quo <= shreg;
                  rem <= partial;
                  dbz <= 1'b0;
               end
               rdy <= 1'b1;
            end
            default: begin
               rdy <= 1'b0;
            end
         endcase
      end
   end

endmodule
